ram_line_responder: RTL and testbench

- RAM-side responder for the cache's byte-serial line-transfer interface: it answers line fills (reads) and line write-backs (writes) issued by the cache on ram_clk.
- It holds a line-organised backing store and returns or accepts one RAM_WORD_WIDTH beat per acknowledge.
- It is the memory end the cache subsystem connects to in system simulation and FPGA builds.

---
 rtl/ram_line_responder.sv | 148 ++++++++++++++
 tb/tb_ram_line_responder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ram_line_responder.sv
// RAM-side responder for the cache byte-serial line-transfer interface: line fills and write-backs, one beat per ack.
// Optional build macro RAM_BEAT_GAP_EN inserts one idle cycle after every acknowledged beat.
module ram_line_responder #(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int RAM_WORD_WIDTH = 8,
    parameter int LINE_BEATS     = 16,
    parameter int RD_LATENCY     = 3,
    parameter int WR_LATENCY     = 2
) (
    input  logic                      ram_clk,
    input  logic                      rst,
    input  logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic                      ram_avalid,
    input  logic                      ram_rnw,
    input  logic [RAM_WORD_WIDTH-1:0] ram_wdata,
    output logic [RAM_WORD_WIDTH-1:0] ram_rdata,
    output logic                      ram_ack,
    output logic                      busy
);

    localparam int BEAT_W  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int IDX_W   = RAM_ADDR_WIDTH + BEAT_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [LAT_W-1:0]  RD_LOAD   = LAT_W'(RD_LATENCY - 1);
    localparam logic [LAT_W-1:0]  WR_LOAD   = LAT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      rnw_q, rnw_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic                      ack_d;
    logic                      rd_load;
    logic [BEAT_W-1:0]         rd_beat;
    logic                      mem_we;

    // Line-organised store: line address in the upper index bits, beat in the lower ones.
    logic [RAM_WORD_WIDTH-1:0] mem [0:(2**IDX_W)-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        ack_d   = ram_ack;
        rd_load = 1'b0;
        rd_beat = beat_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ram_avalid) begin
                    addr_d  = ram_addr;
                    rnw_d   = ram_rnw;
                    lat_d   = ram_rnw ? RD_LOAD : WR_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!ram_avalid) begin
                    state_d = IDLE;
                end else if (lat_q == '0) begin
                    state_d = BURST;
                    beat_d  = '0;
                    ack_d   = 1'b1;
                    rd_load = rnw_q;
                    rd_beat = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            BURST: begin
                // A dropped request stops the burst before the current beat is stored.
                if (!ram_avalid) begin
                    state_d = IDLE;
                    ack_d   = 1'b0;
                end else if (ram_ack) begin
                    mem_we = !rnw_q;
                    if (beat_q == LAST_BEAT) begin
                        state_d = DONE;
                        ack_d   = 1'b0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
`ifdef RAM_BEAT_GAP_EN
                        ack_d  = 1'b0;
`else
                        ack_d   = 1'b1;
                        rd_load = rnw_q;
                        rd_beat = beat_q + BEAT_W'(1);
`endif
                    end
                end else begin
                    // Only reached after a gap cycle; beat already points at the next beat.
                    ack_d   = 1'b1;
                    rd_load = rnw_q;
                end
            end
            DONE: begin
                if (!ram_avalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ram_clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rnw_q     <= 1'b0;
            lat_q     <= '0;
            beat_q    <= '0;
            ram_ack   <= 1'b0;
            ram_rdata <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            ram_ack <= ack_d;
            if (rd_load) begin
                ram_rdata <= mem[{addr_q, rd_beat}];
            end
        end
    end

    // Store contents survive reset.
    always_ff @(posedge ram_clk) begin
        if (mem_we) begin
            mem[{addr_q, beat_q}] <= ram_wdata;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ram_line_responder.sv
// Directed bench for ram_line_responder: reset, full write/read bursts, abort, back-to-back, async reset mid-burst.
module tb_ram_line_responder;

    localparam int AW = 12;
    localparam int WW = 8;
    localparam int RD = 3;
    localparam int WR = 2;
`ifdef RAM_BEAT_GAP_EN
    localparam int EXP_SPAN = 31;
`else
    localparam int EXP_SPAN = 16;
`endif

    logic          ram_clk;
    logic          rst;
    logic [AW-1:0] ram_addr;
    logic          ram_avalid;
    logic          ram_rnw;
    logic [WW-1:0] ram_wdata;
    logic [WW-1:0] ram_rdata;
    logic          ram_ack;
    logic          busy;

    int n_cmp;
    int n_err;

    logic [WW-1:0] wr_data [16];
    logic [WW-1:0] rd_data [16];
    int            ack_cyc [16];

    ram_line_responder #(
        .RAM_ADDR_WIDTH(AW),
        .RAM_WORD_WIDTH(WW),
        .LINE_BEATS    (16),
        .RD_LATENCY    (RD),
        .WR_LATENCY    (WR)
    ) dut (
        .ram_clk   (ram_clk),
        .rst       (rst),
        .ram_addr  (ram_addr),
        .ram_avalid(ram_avalid),
        .ram_rnw   (ram_rnw),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .busy      (busy)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    task automatic tick();
        @(posedge ram_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request and consumes up to 'stop' acks; a full burst also checks DONE and release.
    task automatic do_burst(input string tag, input logic rnw, input logic [AW-1:0] addr, input int stop);
        int k;
        int n;
        int cyc;
        logic seen_ack;
        ram_addr   = addr;
        ram_rnw    = rnw;
        ram_avalid = 1'b1;
        ram_wdata  = wr_data[0];
        tick();
        check({tag, "_accept_busy"}, 32'(busy), 32'd1);
        ram_addr = ~addr;
        k = 0;
        while (!ram_ack && k < 20) begin
            tick();
            k++;
        end
        check({tag, "_latency"}, 32'(k), rnw ? 32'(RD) : 32'(WR));
        n = 0;
        cyc = 0;
        while (n < stop && cyc < 80) begin
            if (ram_ack) begin
                rd_data[n] = ram_rdata;
                ack_cyc[n] = cyc;
                tick();
                n++;
                if (n < 16) ram_wdata = wr_data[n];
            end else begin
                tick();
            end
            cyc++;
        end
        check({tag, "_acks"}, 32'(n), 32'(stop));
        if (stop == 16) begin
            check({tag, "_ack_drop"}, 32'(ram_ack), 32'd0);
            check({tag, "_span"}, 32'(ack_cyc[15] - ack_cyc[0] + 1), 32'(EXP_SPAN));
            seen_ack = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                seen_ack = seen_ack | ram_ack;
            end
            check({tag, "_no_retrigger"}, 32'(seen_ack), 32'd0);
            check({tag, "_done_busy"}, 32'(busy), 32'd1);
            ram_avalid = 1'b0;
            tick();
            check({tag, "_release_busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        ram_addr   = 12'h0A5;
        ram_avalid = 1'b1;
        ram_rnw    = 1'b0;
        ram_wdata  = 8'h00;
        for (int i = 0; i < 16; i++) wr_data[i] = 8'h00;

        // Reset held with a request pending.
        repeat (3) tick();
        check("rst_ack", 32'(ram_ack), 32'd0);
        check("rst_rdata", 32'(ram_rdata), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        ram_avalid = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_release_busy", 32'(busy), 32'd0);
        check("rst_release_ack", 32'(ram_ack), 32'd0);

        // Write line 0x0A5 with 0x00..0x0F, then read it back.
        for (int i = 0; i < 16; i++) wr_data[i] = 8'(i);
        do_burst("wr_a5", 1'b0, 12'h0A5, 16);
        do_burst("rd_a5", 1'b1, 12'h0A5, 16);
        for (int i = 0; i < 16; i++) check($sformatf("rd_a5_b%0d", i), 32'(rd_data[i]), 32'(i));
        check("rd_a5_hold", 32'(ram_rdata), 32'h0F);

        // Preload line 0x010, then abort a 0xFF write after 5 acks.
        for (int i = 0; i < 16; i++) wr_data[i] = 8'(8'h50 + i);
        do_burst("pre_10", 1'b0, 12'h010, 16);
        for (int i = 0; i < 16; i++) wr_data[i] = 8'hFF;
        do_burst("ab_10", 1'b0, 12'h010, 5);
        ram_avalid = 1'b0;
        tick();
        check("ab_10_ack", 32'(ram_ack), 32'd0);
        check("ab_10_busy", 32'(busy), 32'd0);
        do_burst("rb_10", 1'b1, 12'h010, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("rb_10_b%0d", i), 32'(rd_data[i]), (i < 5) ? 32'hFF : 32'(8'h50 + i));

        // Back-to-back: write 0xFFF, one cycle of deassert inside do_burst, then read.
        for (int i = 0; i < 16; i++) wr_data[i] = 8'(8'hA0 + 3 * i);
        do_burst("wr_fff", 1'b0, 12'hFFF, 16);
        do_burst("rd_fff", 1'b1, 12'hFFF, 16);
        for (int i = 0; i < 16; i++) check($sformatf("rd_fff_b%0d", i), 32'(rd_data[i]), 32'(8'hA0 + 3 * i));

        // Asynchronous reset in the middle of a read burst.
        do_burst("rst_mid", 1'b1, 12'h0A5, 3);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ram_ack), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rdata", 32'(ram_rdata), 32'h00);
        ram_avalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_idle", 32'(busy), 32'd0);

        // Store survives reset.
        do_burst("rd_post_rst", 1'b1, 12'h0A5, 16);
        for (int i = 0; i < 16; i++) check($sformatf("rd_post_rst_b%0d", i), 32'(rd_data[i]), 32'(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
